// File: rtl/tug_speed_round_if.sv
// tug_speed_round_if
// Groups the speed-round sequencer's control and status signals.
//
// Signals:
//   start         request a round (driven by the game controller)
//   speed_right   push counter result: right count > left count
//   speed_tie     push counter result: counts equal
//   speedRound    counting window enable to the push counter
//   speedExit     one-cycle clear pulse to the push counter
//   pos           rope position 0..POS_MAX
//   winner_left   sticky match win by left
//   winner_right  sticky match win by right
//   busy          a round is in progress
//   rounds        completed rounds, saturating at 255
//
// Modports:
//   master  the side that requests rounds and supplies push counter results
//   slave   the sequencer itself
interface tug_speed_round_if;
   logic       start;
   logic       speed_right;
   logic       speed_tie;
   logic       speedRound;
   logic       speedExit;
   logic [3:0] pos;
   logic       winner_left;
   logic       winner_right;
   logic       busy;
   logic [7:0] rounds;

   modport master (
      output start, speed_right, speed_tie,
      input  speedRound, speedExit, pos, winner_left, winner_right, busy, rounds
   );

   modport slave (
      input  start, speed_right, speed_tie,
      output speedRound, speedExit, pos, winner_left, winner_right, busy, rounds
   );
endinterface

// File: rtl/tug_speed_round.sv
// tug_speed_round
// Speed-round sequencer for the tug-of-war game. It opens a counting window
// (speedRound) for the push counter. It then waits for the counter's compare
// to settle and samples the result. It moves the rope one step toward the
// round winner and clears the counter with speedExit. When the rope reaches
// either end, the match winner is latched until reset.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   tug_speed_round_if.slave:
//         start, speed_right, speed_tie in;
//         speedRound, speedExit, pos, winner_left, winner_right, busy, rounds out
//
// Parameters:
//   ROUND_LEN   cycles speedRound stays high per round (1..65535)
//   SETTLE_LEN  idle cycles between window close and sampling (>= 2)
//   POS_MAX     rope end index, even; the rope starts at POS_MAX/2
module tug_speed_round #(
   parameter int ROUND_LEN  = 16,
   parameter int SETTLE_LEN = 2,
   parameter int POS_MAX    = 8
) (
   input  logic               clk,
   input  logic               rst,
   tug_speed_round_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE,
      ROUND,
      SETTLE,
      RESOLVE,
      CLEAR,
      DONE
   } state_t;

   localparam logic [15:0] ROUND_LAST  = 16'(ROUND_LEN - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_LEN - 1);
   localparam logic [3:0]  POS_TOP     = 4'(POS_MAX);
   localparam logic [3:0]  POS_MID     = 4'(POS_MAX / 2);

   state_t      state;
   logic [15:0] timer;
   logic [3:0]  posQ;
   logic [3:0]  posNext;
   logic        speedRoundQ;
   logic        speedExitQ;
   logic        winLeftQ;
   logic        winRightQ;
   logic        busyQ;
   logic [7:0]  roundsQ;

   // Where the rope goes if this cycle were RESOLVE. A tie, including the
   // impossible right-and-tie combination, leaves the rope where it is.
   // The end clamps keep pos inside 0..POS_MAX even if a round were ever
   // resolved at an end.
   always_comb begin
      posNext = posQ;
      if (!bus.speed_tie) begin
         if (bus.speed_right) begin
            if (posQ != POS_TOP) begin
               posNext = posQ + 4'd1;
            end
         end else begin
            if (posQ != 4'd0) begin
               posNext = posQ - 4'd1;
            end
         end
      end
   end

   // Round sequencer. All outputs are registered here and change on the
   // same edge as the state they belong to, so speedRound and busy rise in
   // the first ROUND cycle and speedExit coincides with CLEAR. The timer is
   // zeroed on every state entry and compared against the last cycle of the
   // state it is timing. DONE has no exit except reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= 16'd0;
         posQ        <= POS_MID;
         speedRoundQ <= 1'b0;
         speedExitQ  <= 1'b0;
         winLeftQ    <= 1'b0;
         winRightQ   <= 1'b0;
         busyQ       <= 1'b0;
         roundsQ     <= 8'd0;
      end else begin
         speedExitQ <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state       <= ROUND;
                  timer       <= 16'd0;
                  speedRoundQ <= 1'b1;
                  busyQ       <= 1'b1;
               end
            end
            ROUND: begin
               if (timer == ROUND_LAST) begin
                  state       <= SETTLE;
                  timer       <= 16'd0;
                  speedRoundQ <= 1'b0;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            SETTLE: begin
               if (timer == SETTLE_LAST) begin
                  state <= RESOLVE;
                  timer <= 16'd0;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            RESOLVE: begin
               state      <= CLEAR;
               timer      <= 16'd0;
               speedExitQ <= 1'b1;
               posQ       <= posNext;
               if (roundsQ != 8'hFF) begin
                  roundsQ <= roundsQ + 8'd1;
               end
               if (posNext == POS_TOP) begin
                  winRightQ <= 1'b1;
               end
               if (posNext == 4'd0) begin
                  winLeftQ <= 1'b1;
               end
            end
            CLEAR: begin
               timer <= 16'd0;
               busyQ <= 1'b0;
               if (winLeftQ || winRightQ) begin
                  state <= DONE;
               end else begin
                  state <= IDLE;
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.speedRound   = speedRoundQ;
   assign bus.speedExit    = speedExitQ;
   assign bus.pos          = posQ;
   assign bus.winner_left  = winLeftQ;
   assign bus.winner_right = winRightQ;
   assign bus.busy         = busyQ;
   assign bus.rounds       = roundsQ;

endmodule

// File: tb/tb_tug_speed_round.sv
// tb_tug_speed_round
// Self-checking bench for tug_speed_round with default parameters.
// The reference model tracks the match as plain integers: rope position,
// round count and winner. The expected waveform of each round is derived
// from its cycle index relative to the start pulse.
module tb_tug_speed_round;

   localparam int RL   = 16;
   localparam int SL   = 2;
   localparam int PMAX = 8;
   localparam int R    = RL + SL + 1;

   logic clk;
   logic rst;

   tug_speed_round_if bus ();

   tug_speed_round #(
      .ROUND_LEN  (RL),
      .SETTLE_LEN (SL),
      .POS_MAX    (PMAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks;
   int failures;

   int modelPos;
   int modelRounds;
   bit modelWinL;
   bit modelWinR;

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference model reset: rope centred, no rounds, no winner.
   task automatic modelReset();
      modelPos    = PMAX / 2;
      modelRounds = 0;
      modelWinL   = 1'b0;
      modelWinR   = 1'b0;
   endtask

   // Game rules for one resolved round.
   task automatic modelResolve(input logic r, input logic t);
      if (!t) begin
         if (r) modelPos = (modelPos < PMAX) ? modelPos + 1 : PMAX;
         else   modelPos = (modelPos > 0) ? modelPos - 1 : 0;
      end
      if (modelRounds < 255) modelRounds++;
      if (modelPos == PMAX) modelWinR = 1'b1;
      if (modelPos == 0)    modelWinL = 1'b1;
   endtask

   // Compares the match-status outputs against the model.
   task automatic checkStatus(input string where);
      checkOutput({where, " pos"}, 16'(bus.pos), 16'(modelPos));
      checkOutput({where, " rounds"}, 16'(bus.rounds), 16'(modelRounds));
      checkOutput({where, " winner_left"}, 16'(bus.winner_left), 16'(modelWinL));
      checkOutput({where, " winner_right"}, 16'(bus.winner_right), 16'(modelWinR));
   endtask

   // Holds rst for two cycles; returns at a falling edge with rst low.
   task automatic applyReset();
      bus.start       = 1'b0;
      bus.speed_right = 1'b0;
      bus.speed_tie   = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      modelReset();
   endtask

   // One round: start pulsed in cycle 0, the given result presented in the
   // RESOLVE cycle, random noise on the result inputs in all other cycles,
   // and an extra start pulse in cycle junk (which must be ignored).
   // Called and returns at a falling edge.
   task automatic applyStimulus(input logic r, input logic t, input int junk);
      bit wasDone;
      wasDone = modelWinL || modelWinR;
      bus.start       = 1'b1;
      bus.speed_right = 1'($urandom);
      bus.speed_tie   = 1'($urandom);
      for (int c = 1; c <= R + 2; c++) begin
         @(negedge clk);
         if (c == R + 1 && !wasDone) modelResolve(r, t);
         checkOutput($sformatf("speedRound c%0d", c), 16'(bus.speedRound),
                     16'(!wasDone && c <= RL));
         checkOutput($sformatf("speedExit c%0d", c), 16'(bus.speedExit),
                     16'(!wasDone && c == R + 1));
         checkOutput($sformatf("busy c%0d", c), 16'(bus.busy),
                     16'(!wasDone && c <= R + 1));
         if (c == 1 || c >= R + 1) checkStatus($sformatf("c%0d", c));
         bus.start       = (c == junk);
         bus.speed_right = (c == R) ? r : 1'($urandom);
         bus.speed_tie   = (c == R) ? t : 1'($urandom);
      end
      bus.start = 1'b0;
   endtask

   // Starts a round, then resets it in cycle 8 and checks that the block
   // comes back clean with no speedExit pulse.
   task automatic resetMidRound();
      bus.start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         checkOutput($sformatf("abort speedRound c%0d", c), 16'(bus.speedRound), 16'd1);
         bus.start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      checkOutput("abort speedRound c9", 16'(bus.speedRound), 16'd0);
      checkOutput("abort busy c9", 16'(bus.busy), 16'd0);
      checkOutput("abort speedExit c9", 16'(bus.speedExit), 16'd0);
      checkStatus("abort c9");
      for (int c = 10; c < 30; c++) begin
         @(negedge clk);
         checkOutput($sformatf("abort speedExit c%0d", c), 16'(bus.speedExit), 16'd0);
         checkOutput($sformatf("abort speedRound c%0d", c), 16'(bus.speedRound), 16'd0);
      end
   endtask

   // Test sequence: reset, directed rounds, both match wins, ignored start,
   // mid-round reset, then randomized matches.
   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      modelReset();
      @(negedge clk);

      // Reset values
      applyReset();
      checkOutput("reset speedRound", 16'(bus.speedRound), 16'd0);
      checkOutput("reset speedExit", 16'(bus.speedExit), 16'd0);
      checkOutput("reset busy", 16'(bus.busy), 16'd0);
      checkStatus("reset");

      // Right wins one round
      applyStimulus(1'b1, 1'b0, -1);

      // Tie, and the illegal right+tie combination
      applyReset();
      applyStimulus(1'b0, 1'b1, -1);
      applyStimulus(1'b1, 1'b1, -1);

      // Right match win, then starts ignored in DONE
      applyReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, -1);
      applyStimulus(1'b1, 1'b0, -1);
      applyStimulus(1'b0, 1'b0, 7);

      // Left match win
      applyReset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, -1);

      // Ignored start in cycle 5, reset mid-round, fresh round
      applyReset();
      applyStimulus(1'b1, 1'b0, 5);
      applyReset();
      resetMidRound();
      applyStimulus(1'b0, 1'b0, -1);

      // Randomized matches
      applyReset();
      for (int i = 0; i < 40; i++) begin
         logic r;
         logic t;
         r = 1'($urandom);
         t = ($urandom_range(0, 3) == 0);
         applyStimulus(r, t, int'($urandom_range(2, R)));
         if (modelWinL || modelWinR) begin
            if ($urandom_range(0, 1) == 0) applyStimulus(1'($urandom), 1'b0, -1);
            applyReset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tug_speed_round.md
# tug_speed_round

Speed-round sequencer for the tug-of-war game. It sits directly upstream and downstream of the push counter. It generates the speedRound counting window and the speedExit clear pulse. After the window closes it samples speed_right/speed_tie and moves the rope position one step toward the round winner. When the rope reaches either end, it declares the match winner and holds that result until reset.

## Interface

Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.

Parameters:
- ROUND_LEN, 16: cycles speedRound stays high per round; range 1..65535.
- SETTLE_LEN, 2: idle cycles between window close and sampling; minimum 2, to cover the push counter's registered compare.
- POS_MAX, 8: rope end index; must be even; centre is POS_MAX/2.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: request a round; honoured only in IDLE.
- speed_right, input, 1: from push counter; right count > left count.
- speed_tie, input, 1: from push counter; counts equal.
- speedRound, output, 1: counting window enable to the push counter.
- speedExit, output, 1: one-cycle counter clear to the push counter.
- pos, output, 4: rope position 0..POS_MAX.
- winner_left, output, 1: match won by left (pos==0).
- winner_right, output, 1: match won by right (pos==POS_MAX).
- busy, output, 1: high in ROUND, SETTLE, RESOLVE, CLEAR.
- rounds, output, 8: completed rounds, saturating at 255.

## Operation

- **States:**
  - IDLE: waits for start.
  - ROUND: speedRound=1; 16-bit timer counts ROUND_LEN cycles.
  - SETTLE: SETTLE_LEN cycles; speedRound=0.
  - RESOLVE: 1 cycle; samples inputs.
  - CLEAR: 1 cycle; speedExit=1.
  - DONE: terminal.
- **Transitions:**
  - IDLE→ROUND on start=1.
  - ROUND→SETTLE when the timer reaches ROUND_LEN-1.
  - SETTLE→RESOLVE when the timer reaches SETTLE_LEN-1.
  - RESOLVE→CLEAR always.
  - CLEAR→DONE if either winner flag is set, else CLEAR→IDLE.
  - DONE is left only via rst.
  - The timer clears on every state entry.
- **Resolve rule** (evaluated in RESOLVE):
  - speed_tie=1: pos unchanged. This includes the illegal case speed_right=1 with speed_tie=1.
  - speed_right=1, speed_tie=0: pos+1.
  - Both inputs 0 (left wins): pos-1.
- **Winner flags:** pos never leaves 0..POS_MAX. In RESOLVE, winner_right is set when the updated pos equals POS_MAX, and winner_left when it equals 0. The flags are mutually exclusive and sticky.
- **rounds:** increments by 1 in RESOLVE, saturating at 255.
- **start:** ignored outside IDLE, including DONE. A start held high in IDLE begins back-to-back rounds.
- **Inputs outside RESOLVE:** speed_right/speed_tie are ignored.
- **Reset values:**
  - state IDLE, pos=POS_MAX/2.
  - speedRound=0, speedExit=0.
  - winner_left=0, winner_right=0, busy=0, rounds=0.
- **Reset mid-round:** all outputs take reset values on the next cycle and no speedExit is issued. The push counter is reset by the same rst.

## Timing

- **Round sequence.** Cycle 0 is the cycle in which start=1 is sampled in IDLE.
  - speedRound=1 in cycles 1..ROUND_LEN, exactly ROUND_LEN cycles.
  - SETTLE occupies cycles ROUND_LEN+1..ROUND_LEN+SETTLE_LEN.
  - RESOLVE is cycle R=ROUND_LEN+SETTLE_LEN+1; inputs are sampled there.
  - pos, winner flags and rounds show new values from cycle R+1.
  - speedExit=1 in cycle R+1 only.
  - From cycle R+2 the block is in IDLE (busy=0) or DONE.
- **Round period:** earliest next start is sampled at R+2, giving ROUND_LEN+SETTLE_LEN+3 cycles per round.
- **busy:** rises in cycle 1 and falls in cycle R+2.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

Defaults apply: ROUND_LEN=16, SETTLE_LEN=2, POS_MAX=8, so R=19.

1. **Reset:** assert rst 2 cycles → pos=4; speedRound, speedExit, winner_left, winner_right and busy all 0; rounds=0.
2. **Right wins a round:** start pulse at cycle 0 with speed_right=1, speed_tie=0 → speedRound high in cycles 1..16; speedExit high only in cycle 20; pos=5 and rounds=1 from cycle 20; busy=0 in cycle 21.
3. **Tie, including the illegal input case:**
   - speed_tie=1 in RESOLVE → pos stays 4, rounds=1.
   - speed_right=1 with speed_tie=1 → also no move.
4. **Right match win:** four right-win rounds → pos 5,6,7,8; winner_right=1 in cycle 20 of round 4; state DONE; further start pulses produce no speedRound and pos stays 8.
5. **Left match win:** four rounds with both inputs 0 → pos 3,2,1,0; winner_left=1, winner_right=0; rounds=4.
6. **Ignored start and reset mid-round:**
   - start pulsed at cycle 5 of a round → no effect on timing.
   - rst at cycle 8 of the round → speedRound=0 and pos=4 at cycle 9; no speedExit pulse; a fresh start then runs a full 16-cycle window.
